// File: rtl/core_pkg.sv
// core_pkg: inst bus bit positions, idle instruction word and pass sequencer states
package core_pkg;
  localparam int INST_ACC = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_A_PMEM = 20;
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_A_XMEM = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD = 3;
  localparam int INST_L0_WR = 2;
  localparam int INST_EXECUTE = 1;
  localparam int INST_LOAD = 0;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  typedef enum logic [2:0] {IDLE, W_L0, W_LOAD, W_GAP, A_L0, EXEC, O_DRAIN, DONE} state_t;
endpackage

// File: rtl/xmem_l0_streamer.sv
// xmem_l0_streamer: reads len xmem rows from base and writes them into L0 one cycle later
module xmem_l0_streamer (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [10:0] base,
  input  logic [10:0] len,
  output logic        cen,
  output logic        wen,
  output logic [10:0] addr,
  output logic        l0_wr,
  output logic        last
);
  logic [10:0] t;
  always_ff @(posedge clk)
    t <= (reset || !go) ? '0 : t + 11'd1;
  always_comb begin
    cen = !(go && t < len);
    wen = 1'b1;
    addr = cen ? '0 : base + t;
    l0_wr = go && t != '0;
    last = go && t == len;
  end
endmodule

// File: rtl/kij_pass_sequencer.sv
// kij_pass_sequencer: drives core inst bus through one kernel-position weight/activation/psum pass
module kij_pass_sequencer #(
  parameter int          col     = 8,
  parameter int          len_nij = 36,
  parameter logic [10:0] w_base  = 11'h400,
  parameter logic [10:0] a_base  = 11'h000,
  parameter int          gap     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  kij,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
);
  import core_pkg::*;
  localparam logic [5:0] COL = 6'(col);
  localparam logic [5:0] GAP_M1 = 6'(gap - 1);
  localparam logic [5:0] LEN = 6'(len_nij);
  localparam logic [5:0] LEN_M1 = 6'(len_nij - 1);
  state_t state, nxt;
  logic [5:0] cnt, rd_cnt, wr_cnt;
  logic [3:0] kij_q;
  logic wr_pend, rd;
  logic [33:0] inst_nxt;
  logic [10:0] pmem_addr;
  logic s_go, s_cen, s_wen, s_l0_wr, s_last;
  logic [10:0] s_addr;
  assign s_go = state == W_L0 || state == A_L0;
  assign pmem_addr = 11'(kij_q) * 11'(len_nij) + {5'd0, wr_cnt};
  xmem_l0_streamer u_stream (
    .clk(clk),
    .reset(reset),
    .go(s_go),
    .base(state == A_L0 ? a_base : w_base),
    .len(state == A_L0 ? 11'(len_nij) : 11'(col)),
    .cen(s_cen),
    .wen(s_wen),
    .addr(s_addr),
    .l0_wr(s_l0_wr),
    .last(s_last)
  );
  always_comb begin
    nxt = state;
    inst_nxt = IDLE_INST;
    rd = 1'b0;
    case (state)
      IDLE: nxt = (start && kij <= 4'd8) ? W_L0 : IDLE;
      W_L0, A_L0: begin
        inst_nxt[INST_CEN_XMEM] = s_cen;
        inst_nxt[INST_WEN_XMEM] = s_wen;
        inst_nxt[INST_A_XMEM +: 11] = s_addr;
        inst_nxt[INST_L0_WR] = s_l0_wr;
        nxt = !s_last ? state : (state == W_L0 ? W_LOAD : EXEC);
      end
      W_LOAD: begin
        inst_nxt[INST_LOAD] = 1'b1;
        inst_nxt[INST_L0_RD] = cnt < COL;
        nxt = cnt == COL ? W_GAP : W_LOAD;
      end
      W_GAP: nxt = cnt == GAP_M1 ? A_L0 : W_GAP;
      EXEC: begin
        inst_nxt[INST_EXECUTE] = 1'b1;
        inst_nxt[INST_L0_RD] = 1'b1;
        nxt = cnt == LEN_M1 ? O_DRAIN : EXEC;
      end
      O_DRAIN: begin
        rd = ofifo_valid && rd_cnt < LEN;
        inst_nxt[INST_OFIFO_RD] = rd;
        inst_nxt[INST_CEN_PMEM] = !wr_pend;
        inst_nxt[INST_WEN_PMEM] = !wr_pend;
        inst_nxt[INST_A_PMEM +: 11] = wr_pend ? pmem_addr : '0;
        nxt = (wr_pend && wr_cnt == LEN_M1) ? DONE : O_DRAIN;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      wr_pend <= 1'b0;
      kij_q <= '0;
      inst <= IDLE_INST;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 6'd1;
      kij_q <= state == IDLE ? kij : kij_q;
      rd_cnt <= state == O_DRAIN ? rd_cnt + {5'd0, rd} : '0;
      wr_cnt <= state == O_DRAIN ? wr_cnt + {5'd0, wr_pend} : '0;
      wr_pend <= rd;
      inst <= inst_nxt;
      busy <= nxt != IDLE && nxt != DONE;
      done <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_kij_pass_sequencer.sv
// tb_kij_pass_sequencer: directed checks of pass sequencing, stalls, ignored starts and mid-pass reset
module tb_kij_pass_sequencer;
  import core_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic ofifo_valid = 1'b1;
  logic [3:0] kij = 4'd0;
  logic [33:0] inst;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  logic [33:0] ih [0:199];
  logic bh [0:199];
  logic dh [0:199];
  kij_pass_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .kij(kij),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] k, input int n, input int es, input int sf, input int sn, input int ra);
    kij = k;
    for (int c = 1; c <= n; c++) begin
      start = (c == 1 || c == es);
      ofifo_valid = !(c >= sf && c < sf + sn);
      reset = (c == ra);
      @(posedge clk);
      #1;
      ih[c] = inst;
      bh[c] = busy;
      dh[c] = done;
    end
    start = 1'b0;
    reset = 1'b0;
    ofifo_valid = 1'b1;
  endtask
  task automatic check_pass(input logic [3:0] k, input int s);
    int nx = 0, nl = 0, ne = 0, nr = 0, nb = 0, nd = 0, dc = 0, bad = 0;
    logic [10:0] pa [$];
    for (int c = 1; c <= 160; c++) begin
      nx += int'(!ih[c][INST_CEN_XMEM]);
      nl += int'(ih[c][INST_LOAD]);
      ne += int'(ih[c][INST_EXECUTE]);
      nr += int'(ih[c][INST_OFIFO_RD]);
      nb += int'(bh[c]);
      if (dh[c]) begin
        nd++;
        dc = c;
      end
      if (!ih[c][INST_CEN_PMEM]) begin
        pa.push_back(ih[c][30:20]);
        bad += int'(ih[c][INST_WEN_PMEM]);
      end
      bad += int'(ih[c][33] | ih[c][5] | ih[c][4] | (!ih[c][19] & !ih[c][32]));
    end
    chk("xmem_reads", nx, 44);
    for (int i = 0; i < 8; i++)
      chk("w_addr", {ih[2+i][19], ih[2+i][17:7]}, {1'b0, 11'h400 + 11'(i)});
    chk("w_end_cen", ih[10][19], 1'b1);
    for (int c = 2; c <= 11; c++)
      chk("w_l0_wr", ih[c][2], c >= 3 && c <= 10);
    chk("load_cnt", nl, 9);
    chk("load_edges", {ih[10][0], ih[11][0], ih[19][0], ih[20][0]}, 4'b0110);
    chk("wload_l0_rd", {ih[11][3], ih[18][3], ih[19][3]}, 3'b110);
    for (int c = 20; c <= 29; c++)
      chk("gap_idle", ih[c], IDLE_INST);
    chk("a_first", {ih[30][19], ih[30][17:7]}, 12'h000);
    chk("a_last", {ih[65][19], ih[65][17:7]}, {1'b0, 11'd35});
    chk("a_end_cen", ih[66][19], 1'b1);
    chk("a_l0_wr", {ih[30][2], ih[31][2], ih[66][2], ih[67][2]}, 4'b0110);
    chk("exec_cnt", ne, 36);
    chk("exec_edges", {ih[66][1], ih[67][1], ih[102][1], ih[103][1]}, 4'b0110);
    chk("rd_cnt", nr, 36);
    chk("rd_first", {ih[102][6], ih[103][6]}, 2'b01);
    chk("pmem_cnt", pa.size(), 36);
    for (int i = 0; i < 36 && i < pa.size(); i++)
      chk("pmem_addr", pa[i], int'(k) * 36 + i);
    chk("done_cnt", nd, 1);
    chk("done_cycle", dc, 139 + s);
    chk("busy_cnt", nb, 138 + s);
    chk("busy_edges", {bh[1], bh[138+s], bh[139+s]}, 3'b110);
    chk("bit_audit", bad, 0);
    chk("idle_after", ih[140+s], IDLE_INST);
  endtask
  initial begin
    int n_busy, n_act;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_inst", inst, IDLE_INST);
      chk("rst_busy_done", {busy, done}, 2'b00);
    end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    run(4'd0, 160, 140, 0, 0, 0);
    check_pass(4'd0, 0);
    run(4'd8, 160, 0, 110, 5, 0);
    check_pass(4'd8, 5);
    for (int c = 110; c <= 114; c++)
      chk("stall_no_rd", ih[c][6], 1'b0);
    chk("stall_rd_edges", {ih[109][6], ih[115][6]}, 2'b11);
    run(4'd3, 160, 80, 0, 0, 0);
    check_pass(4'd3, 0);
    run(4'd9, 20, 0, 0, 0, 0);
    n_busy = 0;
    n_act = 0;
    for (int c = 1; c <= 20; c++) begin
      n_busy += int'(bh[c] | dh[c]);
      n_act += int'(ih[c] !== IDLE_INST);
    end
    chk("kij9_busy", n_busy, 0);
    chk("kij9_inst", n_act, 0);
    run(4'd1, 40, 0, 0, 0, 32);
    chk("pre_rst_addr", {ih[31][19], ih[31][17:7], bh[31]}, {1'b0, 11'd1, 1'b1});
    chk("mid_rst_inst", ih[32], IDLE_INST);
    chk("mid_rst_busy", {bh[32], dh[32]}, 2'b00);
    n_act = 0;
    for (int c = 33; c <= 40; c++)
      n_act += int'(ih[c] !== IDLE_INST || bh[c] || dh[c]);
    chk("post_rst_idle", n_act, 0);
    run(4'd1, 160, 0, 0, 0, 0);
    check_pass(4'd1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kij_pass_sequencer.md
Name: kij_pass_sequencer

Overview:
- Replaces hand-written bench stimulus with an RTL controller that runs one complete kernel-position (kij) pass on `core`.
- Per pass: stream 8 weight rows xmem→L0, load them into the PEs, stream activations xmem→L0, execute, then drain OFIFO into psum memory.
- Sits directly upstream of `core` and drives its 34-bit `inst` bus; it observes `ofifo_valid` back from the core.
- A top-level loop issues 9 passes (kij=0..8) before accumulation.

Parameters:
- col, 8, PE columns; number of weight rows per kij.
- row, 8, PE rows (informational; sets `D_xmem` width elsewhere).
- len_nij, 36, activation rows per pass and psum words written per pass.
- w_base, 11'h400, xmem address of the first weight row.
- a_base, 11'h000, xmem address of the first activation row.
- gap, 10, idle cycles between kernel load and activation streaming.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to run a pass.
- kij  in  4  kernel position, 0..8; sampled when `start` is accepted.
- ofifo_valid  in  1  from core; OFIFO holds at least one readable row.
- inst  out  34  core instruction bus, registered.
- busy  out  1  high from accept until `done`.
- done  out  1  one-cycle pulse when the pass completes.

inst bit map:
- [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem.
- [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem.
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.

Behaviour:
- Reset and idle:
  - inst = 34'h1_800C_0000 (CEN/WEN bits of both memories high, all else 0); busy=0, done=0; FSM in IDLE.
  - In every state, any bit not listed below takes its idle value.
  - acc, ififo_wr and ififo_rd are always 0.
  - All outputs come from registers: an FSM decision in cycle c appears on `inst` in cycle c+1.
- Accepting start:
  - `start` is accepted only in IDLE with kij<=8. Otherwise it is ignored: no state change, no pulse.
  - On accept, kij is latched and the FSM moves to W_L0.
- W_L0, col+1 cycles (counter t=0..col):
  - For t<col: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+t.
  - l0_wr=1 for t=1..col. The one-cycle lag matches the xmem read latency.
- W_LOAD, col+1 cycles:
  - load=1 throughout.
  - l0_rd=1 for the first col cycles, 0 on the last.
- W_GAP: `gap` cycles, all idle.
- A_L0, len_nij+1 cycles: same pattern as W_L0, with A_xmem=a_base+t and t<len_nij.
- EXEC: len_nij cycles with execute=1, l0_rd=1.
- O_DRAIN:
  - Runs until len_nij rows have been read.
  - ofifo_rd = ofifo_valid AND (reads issued < len_nij).
  - One cycle after each issued read: CEN_pmem=0, WEN_pmem=0, A_pmem = kij*len_nij + w, where w is the write counter 0..len_nij-1.
  - If ofifo_valid is low, no read is issued that cycle and counters hold; the pass stalls with no timeout.
  - A_pmem is computed at 11 bits; the maximum is 8*36+35 = 323.
- DONE:
  - Entered the cycle after the last pmem write is issued.
  - done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- busy timing: busy=1 starts the cycle after accept and holds through the last O_DRAIN cycle.
- Reset mid-pass: at the next edge the FSM returns to IDLE, outputs take reset values, and counters clear. No partial write is completed.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as done is ignored; a new pass needs start after done.
- Nominal pass length (ofifo_valid always high from the EXEC exit): 9+9+10+37+36+37 cycles, then the done pulse.

Decomposition:
- Shared package `core_pkg` holds:
  - inst bit-position constants (INST_ACC=33 … INST_LOAD=0);
  - IDLE_INST = 34'h1_800C_0000;
  - the FSM state enum {IDLE, W_L0, W_LOAD, W_GAP, A_L0, EXEC, O_DRAIN, DONE}.
- One sub-module is natural: `xmem_l0_streamer`. It takes base, length and go; it produces CEN/WEN/A_xmem plus lagged l0_wr and a last flag. It is reused by W_L0 and A_L0.

Test Plan:
1. Reset high for 3 cycles with start=1 → inst=34'h1_800C_0000, busy=0, done=0 throughout.
2. start, kij=0, ofifo_valid tied 1 → A_xmem sequence 0x400..0x407 with l0_wr lagging by 1; load high for 9 cycles; A_pmem 0..35 with WEN_pmem=0; done pulses once, 139 cycles after start.
3. kij=8, ofifo_valid low for 5 cycles mid-drain → no ofifo_rd during those 5 cycles; pmem addresses 288..323 contiguous with no gaps or repeats; done delayed exactly 5 cycles versus scenario 2.
4. start pulsed during EXEC, and kij=9 while idle → both ignored; busy/done timing unchanged; no pass is launched for kij=9.
5. reset asserted in the 3rd cycle of A_L0 → next cycle inst=idle value; a subsequent start, kij=1 runs a clean full pass with A_pmem 36..71.
6. Bit audit across a full pass → inst[33], inst[5], inst[4] never 1; CEN_xmem and CEN_pmem never low in the same cycle.
